// File: rtl/ex_wb_stage_buffer.sv
// ex_wb_stage_buffer
// EX->WB pipeline buffer: two-entry skid buffer (main + skid) with a
// valid/ready handshake, synchronous flush and per-source forwarding compare.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous discard of all buffered beats
//   in_valid/in_ready upstream handshake (in_ready is a flop)
//   in_data/in_we/in_wsel   ALU result, write enable, destination register
//   out_valid/out_ready     write-back handshake on the head (main) entry
//   out_data/out_we/out_wsel head beat payload (out_we is 0 when out_valid=0)
//   src_sel           NUM_SRC packed source-register selects
//   fwd_hit/fwd_data  combinational forwarding match and value per source
module ex_wb_stage_buffer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_SRC = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_we,
  input  logic [ADDR_W-1:0]           in_wsel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_we,
  output logic [ADDR_W-1:0]           out_wsel,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_sel,
  output logic [NUM_SRC-1:0]          fwd_hit,
  output logic [NUM_SRC*DATA_W-1:0]   fwd_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;

  logic                main_valid_q, main_valid_d;
  logic [DATA_W-1:0]   main_data_q,  main_data_d;
  logic                main_we_q,    main_we_d;
  logic [ADDR_W-1:0]   main_wsel_q,  main_wsel_d;

  logic                skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]   skid_data_q,  skid_data_d;
  logic                skid_we_q,    skid_we_d;
  logic [ADDR_W-1:0]   skid_wsel_q,  skid_wsel_d;

  logic                accept;
  logic                pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = main_valid_q & out_ready;

  // Next-state and entry update logic
  always_comb begin
    state_d      = state_q;
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_we_d    = main_we_q;
    main_wsel_d  = main_wsel_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_we_d    = skid_we_q;
    skid_wsel_d  = skid_wsel_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
          main_we_d    = in_we;
          main_wsel_d  = in_wsel;
          state_d      = ST_FULL;
        end
      end
      ST_FULL: begin
        if (accept && pop) begin
          main_data_d  = in_data;
          main_we_d    = in_we;
          main_wsel_d  = in_wsel;
        end else if (accept) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
          skid_we_d    = in_we;
          skid_wsel_d  = in_wsel;
          state_d      = ST_SKID;
        end else if (pop) begin
          main_valid_d = 1'b0;
          main_we_d    = 1'b0;
          state_d      = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (pop) begin
          main_data_d  = skid_data_q;
          main_we_d    = skid_we_q;
          main_wsel_d  = skid_wsel_q;
          skid_valid_d = 1'b0;
          skid_we_d    = 1'b0;
          state_d      = ST_FULL;
        end
      end
      default: begin
        main_valid_d = 1'b0;
        main_we_d    = 1'b0;
        skid_valid_d = 1'b0;
        skid_we_d    = 1'b0;
        state_d      = ST_EMPTY;
      end
    endcase

    // Flush overrides every handshake outcome; a pop this cycle has already
    // been seen by the consumer, an offered beat is simply dropped.
    if (flush) begin
      main_valid_d = 1'b0;
      main_we_d    = 1'b0;
      skid_valid_d = 1'b0;
      skid_we_d    = 1'b0;
      state_d      = ST_EMPTY;
    end

    // Ready is computed from the next state so it is a pure flop output
    in_ready_d = (state_d != ST_SKID);
  end

  // State and entry registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      in_ready_q   <= 1'b1;
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_we_q    <= 1'b0;
      main_wsel_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_we_q    <= 1'b0;
      skid_wsel_q  <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_we_q    <= main_we_d;
      main_wsel_q  <= main_wsel_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_we_q    <= skid_we_d;
      skid_wsel_q  <= skid_wsel_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_we    = main_valid_q & main_we_q;
  assign out_wsel  = main_wsel_q;

  // Forwarding compare; skid holds the newer beat so it wins over main
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (skid_valid_q && skid_we_q && (skid_wsel_q != '0) &&
          (skid_wsel_q == src_sel[i*ADDR_W +: ADDR_W])) begin
        fwd_hit[i]                  = 1'b1;
        fwd_data[i*DATA_W +: DATA_W] = skid_data_q;
      end else if (main_valid_q && main_we_q && (main_wsel_q != '0) &&
                   (main_wsel_q == src_sel[i*ADDR_W +: ADDR_W])) begin
        fwd_hit[i]                  = 1'b1;
        fwd_data[i*DATA_W +: DATA_W] = main_data_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_wb_stage_buffer.sv
// Self-checking bench for ex_wb_stage_buffer: scoreboard queue of accepted
// beats, compared against the head and forwarding outputs every cycle.
module tb_ex_wb_stage_buffer;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned NUM_SRC = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic                      in_we;
  logic [ADDR_W-1:0]         in_wsel;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic                      out_we;
  logic [ADDR_W-1:0]         out_wsel;
  logic [NUM_SRC*ADDR_W-1:0] src_sel;
  logic [NUM_SRC-1:0]        fwd_hit;
  logic [NUM_SRC*DATA_W-1:0] fwd_data;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              we;
    logic [ADDR_W-1:0] ws;
  } beat_t;

  beat_t sb_q[$];
  int    n_total = 0;
  int    n_bad   = 0;
  int    n_pop   = 0;

  always #5 clk = ~clk;

  ex_wb_stage_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_we(in_we), .in_wsel(in_wsel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_we(out_we), .out_wsel(out_wsel),
    .src_sel(src_sel), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic we,
                       input logic [ADDR_W-1:0] ws);
    in_valid = v;
    in_data  = d;
    in_we    = we;
    in_wsel  = ws;
  endtask

  // Scoreboard monitor: checks DUT against model contents, then advances model
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      check_eq("rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("rst_out_data",  64'(out_data),  64'(0));
      check_eq("rst_in_ready",  64'(in_ready),  64'(1));
      check_eq("rst_fwd_hit",   64'(fwd_hit),   64'(0));
    end else begin
      check_eq("in_ready",  64'(in_ready),  64'(sb_q.size() < 2));
      check_eq("out_valid", 64'(out_valid), 64'(sb_q.size() > 0));
      if (sb_q.size() > 0) begin
        check_eq("out_data", 64'(out_data), 64'(sb_q[0].d));
        check_eq("out_we",   64'(out_we),   64'(sb_q[0].we));
        check_eq("out_wsel", 64'(out_wsel), 64'(sb_q[0].ws));
      end else begin
        check_eq("out_we_idle", 64'(out_we), 64'(0));
      end
      for (int s = 0; s < int'(NUM_SRC); s++) begin
        logic              e_hit;
        logic [DATA_W-1:0] e_dat;
        logic [ADDR_W-1:0] sel;
        e_hit = 1'b0;
        e_dat = '0;
        sel   = src_sel[s*ADDR_W +: ADDR_W];
        for (int e = sb_q.size() - 1; e >= 0; e--) begin
          if (!e_hit && sb_q[e].we && sb_q[e].ws != '0 && sb_q[e].ws == sel) begin
            e_hit = 1'b1;
            e_dat = sb_q[e].d;
          end
        end
        check_eq($sformatf("fwd_hit%0d", s),  64'(fwd_hit[s]), 64'(e_hit));
        check_eq($sformatf("fwd_data%0d", s), 64'(fwd_data[s*DATA_W +: DATA_W]), 64'(e_dat));
      end
      begin
        logic acc;
        beat_t b;
        acc = in_valid && (sb_q.size() < 2);
        if (sb_q.size() > 0 && out_ready) begin
          void'(sb_q.pop_front());
          n_pop++;
        end
        if (flush) sb_q.delete();
        else if (acc) begin
          b.d = in_data; b.we = in_we; b.ws = in_wsel;
          sb_q.push_back(b);
        end
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; src_sel = '0;
    drive(1'b0, '0, 1'b0, '0);
    cyc(); cyc();
    check_eq("reset_out_we",   64'(out_we),   64'(0));
    check_eq("reset_out_wsel", 64'(out_wsel), 64'(0));
    check_eq("reset_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;

    // Reset then stream four beats
    out_ready = 1'b1;
    base = n_pop;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, DATA_W'(k * 'h11), 1'b1, ADDR_W'(k));
      cyc();
      check_eq("stream_out_data", 64'(out_data), 64'(k * 'h11));
      check_eq("stream_in_ready", 64'(in_ready), 64'(1));
    end
    drive(1'b0, '0, 1'b0, '0);
    cyc(); cyc();
    check_eq("stream_cnt", 64'(n_pop - base), 64'(4));

    // Back-pressure: A in main, B in skid, C held upstream
    out_ready = 1'b0;
    base = n_pop;
    drive(1'b1, 32'hA, 1'b1, 5'd1); cyc();
    drive(1'b1, 32'hB, 1'b1, 5'd2); cyc();
    check_eq("bp_in_ready", 64'(in_ready), 64'(0));
    check_eq("bp_head",     64'(out_data), 64'(32'hA));
    drive(1'b1, 32'hC, 1'b1, 5'd3); cyc();
    check_eq("bp_head_hold", 64'(out_data), 64'(32'hA));
    out_ready = 1'b1;
    cyc();
    cyc();
    drive(1'b0, '0, 1'b0, '0);
    cyc(); cyc();
    check_eq("bp_cnt", 64'(n_pop - base), 64'(3));

    // Flush while in SKID with a beat offered
    out_ready = 1'b0;
    drive(1'b1, 32'h71, 1'b1, 5'd6); cyc();
    drive(1'b1, 32'h72, 1'b1, 5'd7); cyc();
    flush = 1'b1;
    drive(1'b1, 32'hDEAD, 1'b1, 5'd9); cyc();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    check_eq("flush_out_valid", 64'(out_valid), 64'(0));
    check_eq("flush_in_ready",  64'(in_ready),  64'(1));
    check_eq("flush_out_we",    64'(out_we),    64'(0));
    out_ready = 1'b1;
    cyc(); cyc();
    check_eq("flush_no_dead", 64'(out_valid), 64'(0));

    // Forwarding priority: skid over main
    out_ready = 1'b0;
    src_sel = {5'd7, 5'd5};
    drive(1'b1, 32'h100, 1'b1, 5'd5); cyc();
    drive(1'b1, 32'h200, 1'b1, 5'd5); cyc();
    drive(1'b0, '0, 1'b0, '0);
    check_eq("fwd_prio_hit",  64'(fwd_hit),  64'(2'b01));
    check_eq("fwd_prio_data", 64'(fwd_data), 64'({32'h0, 32'h200}));
    flush = 1'b1; cyc(); flush = 1'b0;

    // Zero register and we=0 never forward
    src_sel = {5'd3, 5'd0};
    drive(1'b1, 32'h9, 1'b1, 5'd0); cyc();
    drive(1'b1, 32'h8, 1'b0, 5'd3); cyc();
    drive(1'b0, '0, 1'b0, '0);
    check_eq("fwd_zero_hit",  64'(fwd_hit),  64'(0));
    check_eq("fwd_zero_data", 64'(fwd_data), 64'(0));

    // Asynchronous reset between edges while in SKID
    src_sel = {5'd3, 5'd3};
    #2 rst = 1'b1;
    #1;
    check_eq("arst_out_valid", 64'(out_valid), 64'(0));
    check_eq("arst_out_data",  64'(out_data),  64'(0));
    check_eq("arst_out_we",    64'(out_we),    64'(0));
    check_eq("arst_out_wsel",  64'(out_wsel),  64'(0));
    check_eq("arst_in_ready",  64'(in_ready),  64'(1));
    check_eq("arst_fwd_hit",   64'(fwd_hit),   64'(0));
    check_eq("arst_fwd_data",  64'(fwd_data),  64'(0));
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h55, 1'b1, 5'd2); cyc();
    drive(1'b0, '0, 1'b0, '0);
    check_eq("arst_new_valid", 64'(out_valid), 64'(1));
    check_eq("arst_new_data",  64'(out_data),  64'(32'h55));
    cyc();
    check_eq("arst_alone", 64'(out_valid), 64'(0));

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            ADDR_W'($urandom_range(0, 7)));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 19) == 0);
      src_sel   = {ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7))};
      cyc();
    end
    drive(1'b0, '0, 1'b0, '0);
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    check_eq("drain_empty", 64'(out_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
